// File: rtl/note_player.sv
// note_player -- plays one note at a time for a tone generator.
//
// A song controller presents note/duration with a level request (new_note).
// The player walks IDLE -> LOAD -> PLAY -> DONE -> IDLE. It latches the note
// in LOAD, counts beats down in PLAY, and pulses note_done in DONE. During
// PLAY it advances a 20-bit phase accumulator by the note's step size on
// each codec sample request. play=0 freezes all progress.
//
// Ports:
//   clk          in   system clock, all state on the rising edge
//   reset        in   asynchronous, active-high
//   play         in   1 = playing, 0 = pause (freeze)
//   new_note     in   request: note/duration valid
//   note[5:0]    in   note index, 0 = rest
//   duration[5:0]in   note length in beats
//   beat         in   one-cycle beat pulse
//   next_sample  in   one-cycle sample request
//   note_done    out  one-cycle pulse when the current note finishes
//   step_size    out  phase increment of the sounding note (0 when silent)
//   phase        out  phase accumulator
//   sample_valid out  one-cycle pulse after phase has been updated
//
// Build option: define NOTE_PLAYER_GAP_EN to silence the final beat of every
// note that lasts two or more beats (articulation gap). The phase holds
// during the gap because the increment is zero.
module note_player (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic        new_note,
    input  logic [5:0]  note,
    input  logic [5:0]  duration,
    input  logic        beat,
    input  logic        next_sample,
    output logic        note_done,
    output logic [19:0] step_size,
    output logic [19:0] phase,
    output logic        sample_valid
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  note_q, note_d;
    logic [5:0]  rem_q, rem_d;
    logic [19:0] phase_q, phase_d;
    logic [19:0] step_q, step_d;
    logic        sv_q, sv_d;
`ifdef NOTE_PLAYER_GAP_EN
    logic [5:0]  dur_q, dur_d;
`endif

    // Phase increment per 48 kHz sample: round(440*2^((n-49)/12)*2^20/48000).
    function automatic logic [19:0] step_lut(input logic [5:0] n);
        logic [19:0] s;
        case (n)
            6'd1:  s = 20'd601;   6'd2:  s = 20'd636;   6'd3:  s = 20'd674;   6'd4:  s = 20'd714;
            6'd5:  s = 20'd757;   6'd6:  s = 20'd802;   6'd7:  s = 20'd850;   6'd8:  s = 20'd900;
            6'd9:  s = 20'd954;   6'd10: s = 20'd1010;  6'd11: s = 20'd1070;  6'd12: s = 20'd1134;
            6'd13: s = 20'd1201;  6'd14: s = 20'd1273;  6'd15: s = 20'd1349;  6'd16: s = 20'd1429;
            6'd17: s = 20'd1514;  6'd18: s = 20'd1604;  6'd19: s = 20'd1699;  6'd20: s = 20'd1800;
            6'd21: s = 20'd1907;  6'd22: s = 20'd2021;  6'd23: s = 20'd2141;  6'd24: s = 20'd2268;
            6'd25: s = 20'd2403;  6'd26: s = 20'd2546;  6'd27: s = 20'd2697;  6'd28: s = 20'd2858;
            6'd29: s = 20'd3028;  6'd30: s = 20'd3208;  6'd31: s = 20'd3398;  6'd32: s = 20'd3600;
            6'd33: s = 20'd3815;  6'd34: s = 20'd4041;  6'd35: s = 20'd4282;  6'd36: s = 20'd4536;
            6'd37: s = 20'd4806;  6'd38: s = 20'd5092;  6'd39: s = 20'd5395;  6'd40: s = 20'd5715;
            6'd41: s = 20'd6055;  6'd42: s = 20'd6415;  6'd43: s = 20'd6797;  6'd44: s = 20'd7201;
            6'd45: s = 20'd7629;  6'd46: s = 20'd8083;  6'd47: s = 20'd8563;  6'd48: s = 20'd9072;
            6'd49: s = 20'd9612;  6'd50: s = 20'd10184; 6'd51: s = 20'd10789; 6'd52: s = 20'd11431;
            6'd53: s = 20'd12110; 6'd54: s = 20'd12830; 6'd55: s = 20'd13593; 6'd56: s = 20'd14402;
            6'd57: s = 20'd15258; 6'd58: s = 20'd16165; 6'd59: s = 20'd17127; 6'd60: s = 20'd18145;
            6'd61: s = 20'd19224; 6'd62: s = 20'd20367; 6'd63: s = 20'd21578;
            default: s = 20'd0;   // note 0 is a rest
        endcase
        return s;
    endfunction

    // In LOAD the step register is filled straight from the input note so the
    // table value is already present in the first PLAY cycle.
    logic [19:0] lut_val;
    assign lut_val = step_lut((state_q == LOAD) ? note : note_q);

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        rem_d   = rem_q;
        phase_d = phase_q;
        step_d  = step_q;
        sv_d    = 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
        dur_d   = dur_q;
`endif
        case (state_q)
            IDLE: begin
                step_d = 20'd0;
                if (new_note && play) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                note_d  = note;
                rem_d   = duration;
                phase_d = 20'd0;
`ifdef NOTE_PLAYER_GAP_EN
                dur_d   = duration;
`endif
                // A one-beat note never gaps, so no gap test is needed here.
                if (duration == 6'd0) begin
                    state_d = DONE;
                    step_d  = 20'd0;
                end else begin
                    state_d = PLAY;
                    step_d  = lut_val;
                end
            end
            PLAY: begin
                if (play) begin
                    // Sample and beat are independent; both may land together.
                    if (next_sample) begin
                        phase_d = phase_q + step_q;
                        sv_d    = 1'b1;
                    end
                    if (beat) begin
                        rem_d = rem_q - 6'd1;
                        if (rem_q == 6'd1) begin
                            state_d = DONE;
                        end
                    end
                end
                if (state_d == DONE) begin
                    step_d = 20'd0;
                end else begin
`ifdef NOTE_PLAYER_GAP_EN
                    step_d = (rem_d == 6'd1 && dur_q >= 6'd2) ? 20'd0 : lut_val;
`else
                    step_d = lut_val;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                step_d  = 20'd0;
            end
            default: begin
                state_d = IDLE;
                step_d  = 20'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            note_q  <= 6'd0;
            rem_q   <= 6'd0;
            phase_q <= 20'd0;
            step_q  <= 20'd0;
            sv_q    <= 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
            dur_q   <= 6'd0;
`endif
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            rem_q   <= rem_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            sv_q    <= sv_d;
`ifdef NOTE_PLAYER_GAP_EN
            dur_q   <= dur_d;
`endif
        end
    end

    assign note_done    = (state_q == DONE);
    assign step_size    = step_q;
    assign phase        = phase_q;
    assign sample_valid = sv_q;

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        new_note;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        beat;
    logic        next_sample;
    logic        note_done;
    logic [19:0] step_size;
    logic [19:0] phase;
    logic        sample_valid;

    always #5 clk = ~clk;

`ifdef NOTE_PLAYER_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    note_player dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .new_note     (new_note),
        .note         (note),
        .duration     (duration),
        .beat         (beat),
        .next_sample  (next_sample),
        .note_done    (note_done),
        .step_size    (step_size),
        .phase        (phase),
        .sample_valid (sample_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT just after the edge that exits LOAD.
    task automatic start_note(input logic [5:0] n, input logic [5:0] d);
        note     = n;
        duration = d;
        new_note = 1'b1;
        play     = 1'b1;
        step();
        check("load_step_zero", {12'd0, step_size}, 32'd0);
        new_note = 1'b0;
        step();
    endtask

    task automatic beat_once();
        beat = 1'b1;
        step();
        beat = 1'b0;
    endtask

    task automatic sample_once();
        next_sample = 1'b1;
        step();
        next_sample = 1'b0;
        check("sample_valid_pulse", {31'd0, sample_valid}, 32'd1);
    endtask

    typedef struct {
        logic [5:0]  n;
        logic [19:0] exp_step;
    } vec_t;

    vec_t vecs[10];

    logic [19:0] gap_step;
    logic [19:0] pat_step[8];
    logic        pat_done[8];
    int          sv_cnt;
    int          done_cnt;

    initial begin
        vecs[0] = '{6'd0,  20'd0};
        vecs[1] = '{6'd1,  20'd601};
        vecs[2] = '{6'd12, 20'd1134};
        vecs[3] = '{6'd33, 20'd3815};
        vecs[4] = '{6'd37, 20'd4806};
        vecs[5] = '{6'd49, 20'd9612};
        vecs[6] = '{6'd50, 20'd10184};
        vecs[7] = '{6'd57, 20'd15258};
        vecs[8] = '{6'd62, 20'd20367};
        vecs[9] = '{6'd63, 20'd21578};

        reset = 1'b1; play = 1'b0; new_note = 1'b0; note = 6'd0;
        duration = 6'd0; beat = 1'b0; next_sample = 1'b0;
        step();
        step();
        check("reset_note_done", {31'd0, note_done}, 32'd0);
        check("reset_step", {12'd0, step_size}, 32'd0);
        check("reset_phase", {12'd0, phase}, 32'd0);
        check("reset_sample_valid", {31'd0, sample_valid}, 32'd0);
        reset = 1'b0;
        step();

        // Table lookup: one-beat note, one sample, then finish.
        foreach (vecs[i]) begin
            start_note(vecs[i].n, 6'd1);
            check($sformatf("step_n%0d", vecs[i].n), {12'd0, step_size}, {12'd0, vecs[i].exp_step});
            sample_once();
            check($sformatf("phase_n%0d", vecs[i].n), {12'd0, phase}, {12'd0, vecs[i].exp_step});
            beat_once();
            check("vec_note_done", {31'd0, note_done}, 32'd1);
            check("vec_done_step", {12'd0, step_size}, 32'd0);
            step();
            check("vec_done_clear", {31'd0, note_done}, 32'd0);
        end

        // Note 49, three beats, four samples.
        start_note(6'd49, 6'd3);
        check("n49_step", {12'd0, step_size}, 32'd9612);
        for (int i = 0; i < 4; i++) sample_once();
        check("n49_phase4", {12'd0, phase}, 32'd38448);
        beat_once();
        check("n49_beat1_done", {31'd0, note_done}, 32'd0);
        check("n49_beat1_step", {12'd0, step_size}, 32'd9612);
        beat_once();
        check("n49_beat2_done", {31'd0, note_done}, 32'd0);
        check("n49_beat2_step", {12'd0, step_size}, 32'd9612);
        beat_once();
        check("n49_beat3_done", {31'd0, note_done}, 32'd1);
        step();
        check("n49_done_once", {31'd0, note_done}, 32'd0);

        // Zero duration: LOAD then DONE, beat/sample ignored, no samples.
        note = 6'd5; duration = 6'd0; new_note = 1'b1; play = 1'b1;
        step();
        check("dur0_load_done", {31'd0, note_done}, 32'd0);
        new_note = 1'b0; beat = 1'b1; next_sample = 1'b1;
        step();
        check("dur0_done", {31'd0, note_done}, 32'd1);
        check("dur0_sv_a", {31'd0, sample_valid}, 32'd0);
        step();
        check("dur0_sv_b", {31'd0, sample_valid}, 32'd0);
        check("dur0_done_clear", {31'd0, note_done}, 32'd0);
        check("dur0_phase", {12'd0, phase}, 32'd0);
        beat = 1'b0; next_sample = 1'b0;
        step();

        // Pause for 10 beats mid-note.
        start_note(6'd20, 6'd4);
        check("pause_step", {12'd0, step_size}, 32'd1800);
        sample_once();
        sample_once();
        beat_once();
        play = 1'b0;
        sv_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            beat = 1'b1; next_sample = 1'b1;
            step();
            sv_cnt += int'(sample_valid);
            done_cnt += int'(note_done);
            beat = 1'b0; next_sample = 1'b0;
            step();
            sv_cnt += int'(sample_valid);
        end
        check("pause_no_samples", sv_cnt, 32'd0);
        check("pause_no_done", done_cnt, 32'd0);
        check("pause_phase", {12'd0, phase}, 32'd3600);
        play = 1'b1;
        sample_once();
        check("resume_phase", {12'd0, phase}, 32'd5400);
        beat_once();
        check("resume_beat2", {31'd0, note_done}, 32'd0);
        beat_once();
        check("resume_beat3", {31'd0, note_done}, 32'd0);
        beat_once();
        check("resume_beat4", {31'd0, note_done}, 32'd1);
        step();

        // Phase wrap with note 63; every 10th sample coincides with a beat.
        start_note(6'd63, 6'd40);
        sv_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            next_sample = 1'b1;
            beat = (i % 10 == 9);
            step();
            sv_cnt += int'(sample_valid);
        end
        next_sample = 1'b0; beat = 1'b0;
        check("wrap_sample_count", sv_cnt, 32'd200);
        check("wrap_phase", {12'd0, phase}, 32'd121296);
        check("wrap_step", {12'd0, step_size}, 32'd21578);
        done_cnt = 0;
        for (int i = 0; i < 19; i++) begin
            beat_once();
            done_cnt += int'(note_done);
        end
        check("wrap_no_early_done", done_cnt, 32'd0);
        beat_once();
        check("wrap_done_after_40", {31'd0, note_done}, 32'd1);
        step();

        // Final-beat articulation gap (zero only in the gapped build).
        gap_step = GAP_ON ? 20'd0 : 20'd9612;
        start_note(6'd49, 6'd4);
        check("gap_beat1", {12'd0, step_size}, 32'd9612);
        beat_once();
        check("gap_beat2", {12'd0, step_size}, 32'd9612);
        beat_once();
        check("gap_beat3", {12'd0, step_size}, 32'd9612);
        beat_once();
        check("gap_final_beat", {12'd0, step_size}, {12'd0, gap_step});
        sample_once();
        check("gap_phase", {12'd0, phase}, {12'd0, gap_step});
        beat_once();
        check("gap_done", {31'd0, note_done}, 32'd1);
        step();

        // Back-to-back notes: request, beat held high, note changed mid-PLAY.
        pat_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        pat_step = '{20'd0, 20'd9612, 20'd0, 20'd0, 20'd0, 20'd4806, 20'd0, 20'd0};
        note = 6'd49; duration = 6'd1; new_note = 1'b1; play = 1'b1; beat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 1) note = 6'd37;
            check($sformatf("b2b_done_%0d", i), {31'd0, note_done}, {31'd0, pat_done[i]});
            check($sformatf("b2b_step_%0d", i), {12'd0, step_size}, {12'd0, pat_step[i]});
        end
        new_note = 1'b0; beat = 1'b0;
        step();

        // Reset mid-PLAY: everything clears at once, no note_done afterwards.
        start_note(6'd49, 6'd5);
        sample_once();
        sample_once();
        beat_once();
        beat_once();
        reset = 1'b1;
        #1;
        check("rst_mid_step", {12'd0, step_size}, 32'd0);
        check("rst_mid_phase", {12'd0, phase}, 32'd0);
        check("rst_mid_done", {31'd0, note_done}, 32'd0);
        check("rst_mid_sv", {31'd0, sample_valid}, 32'd0);
        step();
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            beat = 1'b1;
            step();
            done_cnt += int'(note_done);
        end
        beat = 1'b0;
        check("rst_no_done", done_cnt, 32'd0);
        start_note(6'd37, 6'd1);
        check("rst_restart_step", {12'd0, step_size}, 32'd4806);
        beat_once();
        check("rst_restart_done", {31'd0, note_done}, 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
